// File: rtl/ring_sequence_checker_if.sv
// Bundle of sample inputs and checker status outputs for ring_sequence_checker.
// Master drives the ring sample; slave is the checker.
interface ring_sequence_checker_if #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned ERR_CNT_W = 8
);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  logic                 in_valid;
  logic [WIDTH-1:0]     in_ring;
  logic                 clr_err;
  logic                 idx_valid;
  logic [IDX_W-1:0]     idx;
  logic                 onehot_ok;
  logic                 locked;
  logic                 seq_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_ring, clr_err,
    input  idx_valid, idx, onehot_ok, locked, seq_err, err_count
  );

  modport slave (
    input  in_valid, in_ring, clr_err,
    output idx_valid, idx, onehot_ok, locked, seq_err, err_count
  );
endinterface

// File: rtl/ring_sequence_checker.sv
// Checks a sampled one-hot ring vector: decodes its position, verifies single-step
// progression, locks after LOCK_COUNT good samples and counts sequence errors.
module ring_sequence_checker #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned DIR        = 0,
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input logic                      clk,
  input logic                      rstn,
  ring_sequence_checker_if.slave   bus
);
  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(LOCK_COUNT + 2);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     good_cnt_q, good_cnt_d;
  logic [IDX_W-1:0]     prev_q, prev_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 idx_valid_q, idx_valid_d;
  logic                 onehot_ok_q, onehot_ok_d;
  logic                 locked_q, locked_d;
  logic                 seq_err_q, seq_err_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic                 onehot_c;
  logic [IDX_W-1:0]     dec_c;
  logic [IDX_W-1:0]     expected_c;
  logic                 match_c;

  // One-hot test, binary decode and next expected position from the last good sample.
  always_comb begin
    onehot_c = (bus.in_ring != '0) && ((bus.in_ring & (bus.in_ring - WIDTH'(1))) == '0);
    dec_c    = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (bus.in_ring[i]) dec_c = dec_c | IDX_W'(i);
    end
    if (DIR == 0) expected_c = (prev_q == IDX_W'(WIDTH - 1)) ? '0 : prev_q + IDX_W'(1);
    else          expected_c = (prev_q == '0) ? IDX_W'(WIDTH - 1) : prev_q - IDX_W'(1);
    match_c = (dec_c == expected_c);
  end

  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    prev_d      = prev_q;
    idx_d       = idx_q;
    idx_valid_d = 1'b0;
    onehot_ok_d = onehot_ok_q;
    seq_err_d   = 1'b0;
    err_count_d = err_count_q;

    if (bus.in_valid) begin
      onehot_ok_d = onehot_c;
      idx_valid_d = onehot_c;
      if (onehot_c) begin
        idx_d  = dec_c;
        prev_d = dec_c;
      end
      unique case (state_q)
        HUNT: begin
          if (onehot_c) begin
            good_cnt_d = CNT_W'(1);
            state_d    = (LOCK_COUNT == 1) ? LOCKED : SYNC;
          end
        end
        SYNC: begin
          if (!onehot_c) begin
            state_d    = HUNT;
            good_cnt_d = '0;
          end else if (match_c) begin
            good_cnt_d = good_cnt_q + CNT_W'(1);
            if (good_cnt_d >= CNT_W'(LOCK_COUNT)) state_d = LOCKED;
          end else begin
            good_cnt_d = CNT_W'(1);
          end
        end
        LOCKED: begin
          if (!onehot_c) begin
            seq_err_d  = 1'b1;
            state_d    = HUNT;
            good_cnt_d = '0;
          end else if (!match_c) begin
            seq_err_d  = 1'b1;
            state_d    = SYNC;
            good_cnt_d = CNT_W'(1);
          end
        end
        default: begin
          state_d    = HUNT;
          good_cnt_d = '0;
        end
      endcase
    end

    locked_d = (state_d == LOCKED);

    // Clear has priority over a simultaneous error; counter saturates at all-ones.
    if (bus.clr_err)                                err_count_d = '0;
    else if (seq_err_d && (err_count_q != '1))      err_count_d = err_count_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= HUNT;
      good_cnt_q  <= '0;
      prev_q      <= '0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      onehot_ok_q <= 1'b0;
      locked_q    <= 1'b0;
      seq_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      good_cnt_q  <= good_cnt_d;
      prev_q      <= prev_d;
      idx_q       <= idx_d;
      idx_valid_q <= idx_valid_d;
      onehot_ok_q <= onehot_ok_d;
      locked_q    <= locked_d;
      seq_err_q   <= seq_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.idx_valid = idx_valid_q;
  assign bus.idx       = idx_q;
  assign bus.onehot_ok = onehot_ok_q;
  assign bus.locked    = locked_q;
  assign bus.seq_err   = seq_err_q;
  assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_ring_sequence_checker.sv
// Bench for ring_sequence_checker: two instances (DIR=0 with 2-bit error counter, DIR=1 with
// 8-bit counter) share one stimulus stream and are checked each cycle against a streak model.
module tb_ring_sequence_checker;
  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       v = 1'b0;
  logic [3:0] ring = 4'b0000;
  logic       clr = 1'b0;

  int total = 0;
  int bad   = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  ring_sequence_checker_if #(.WIDTH(4), .ERR_CNT_W(2)) ifa ();
  ring_sequence_checker_if #(.WIDTH(4), .ERR_CNT_W(8)) ifb ();

  assign ifa.in_valid = v;
  assign ifa.in_ring  = ring;
  assign ifa.clr_err  = clr;
  assign ifb.in_valid = v;
  assign ifb.in_ring  = ring;
  assign ifb.clr_err  = clr;

  ring_sequence_checker #(.WIDTH(4), .DIR(0), .LOCK_COUNT(3), .ERR_CNT_W(2)) dut_a (
    .clk(clk), .rstn(rstn), .bus(ifa));
  ring_sequence_checker #(.WIDTH(4), .DIR(1), .LOCK_COUNT(3), .ERR_CNT_W(8)) dut_b (
    .clk(clk), .rstn(rstn), .bus(ifb));

  // Model: a streak is the run of consecutive valid one-hot samples each one step from the
  // previous. Locked means streak >= 3; an error is any valid sample that ends a locked streak.
  localparam int W  = 4;
  localparam int LC = 3;
  int dir_m [2] = '{0, 1};
  int emax_m[2] = '{3, 255};

  int m_streak[2], m_prev[2], m_idx[2], m_err[2];
  bit m_iv[2], m_oh[2], m_lk[2], m_se[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rstn) begin
        m_streak[k] = 0; m_prev[k] = 0; m_idx[k] = 0; m_err[k] = 0;
        m_iv[k] = 0; m_oh[k] = 0; m_lk[k] = 0; m_se[k] = 0;
      end else begin
        m_iv[k] = 0;
        m_se[k] = 0;
        if (v) begin
          int  pos, nxt, ns;
          bit  oh;
          oh  = ($countones(ring) == 1);
          pos = 0;
          for (int i = 0; i < W; i++) if (ring[i]) pos = i;
          nxt = (dir_m[k] == 0) ? (m_prev[k] + 1) % W : (m_prev[k] + W - 1) % W;
          if (!oh)                                  ns = 0;
          else if (m_streak[k] > 0 && pos == nxt)   ns = m_streak[k] + 1;
          else                                      ns = 1;
          if (m_streak[k] >= LC && ns != m_streak[k] + 1) m_se[k] = 1;
          m_oh[k] = oh;
          m_iv[k] = oh;
          if (oh) begin
            m_idx[k]  = pos;
            m_prev[k] = pos;
          end
          m_streak[k] = ns;
          m_lk[k]     = (ns >= LC);
        end
        if (clr)           m_err[k] = 0;
        else if (m_se[k])  m_err[k] = (m_err[k] + 1 > emax_m[k]) ? emax_m[k] : m_err[k] + 1;
      end
    end
    started = 1'b1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int k, input logic iv, input logic [1:0] ix, input logic oh,
                           input logic lk, input logic se, input logic [7:0] ec);
    string p;
    p = $sformatf("model dut%0d", k);
    check({p, ".idx_valid"}, 32'(iv), 32'(m_iv[k]));
    check({p, ".idx"},       32'(ix), 32'(m_idx[k]));
    check({p, ".onehot_ok"}, 32'(oh), 32'(m_oh[k]));
    check({p, ".locked"},    32'(lk), 32'(m_lk[k]));
    check({p, ".seq_err"},   32'(se), 32'(m_se[k]));
    check({p, ".err_count"}, 32'(ec), 32'(m_err[k]));
  endtask

  always @(negedge clk) begin
    if (started) begin
      check_dut(0, ifa.idx_valid, ifa.idx, ifa.onehot_ok, ifa.locked, ifa.seq_err, 8'(ifa.err_count));
      check_dut(1, ifb.idx_valid, ifb.idx, ifb.onehot_ok, ifb.locked, ifb.seq_err, ifb.err_count);
    end
  end

  // One sample per cycle; returns just after the edge that registers it.
  task automatic step(input bit val, input logic [3:0] r, input bit c = 1'b0, input bit rs = 1'b1);
    @(negedge clk);
    v = val; ring = r; clr = c; rstn = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    step(0, 4'b0000, 0, 0);
    step(1, 4'b0001, 0, 0);
    check("rst a.idx_valid", 32'(ifa.idx_valid), 0);
    check("rst a.locked",    32'(ifa.locked), 0);
    check("rst b.err_count", 32'(ifb.err_count), 0);

    // Increment sequence on A
    step(1, 4'b0001); check("t1 a.idx0", 32'(ifa.idx), 0); check("t1 a.idx_valid", 32'(ifa.idx_valid), 1);
    step(1, 4'b0010); check("t1 a.idx1", 32'(ifa.idx), 1); check("t1 a.locked2", 32'(ifa.locked), 0);
    step(1, 4'b0100); check("t1 a.idx2", 32'(ifa.idx), 2); check("t1 a.locked3", 32'(ifa.locked), 1);
    step(1, 4'b1000); check("t1 a.idx3", 32'(ifa.idx), 3);
    step(1, 4'b0001); check("t1 a.idx_wrap", 32'(ifa.idx), 0); check("t1 a.locked5", 32'(ifa.locked), 1);

    // Skip while locked, then relock
    step(1, 4'b0100);
    check("t2 a.seq_err", 32'(ifa.seq_err), 1); check("t2 a.err_count", 32'(ifa.err_count), 1);
    check("t2 a.locked", 32'(ifa.locked), 0);   check("t2 a.idx", 32'(ifa.idx), 2);
    step(1, 4'b1000); check("t2 a.seq_err_clr", 32'(ifa.seq_err), 0);
    step(1, 4'b0001); check("t2 a.relock", 32'(ifa.locked), 1); check("t2 a.seq_err_none", 32'(ifa.seq_err), 0);

    // Invalid vectors while locked
    step(1, 4'b0011);
    check("t3 a.onehot_ok", 32'(ifa.onehot_ok), 0); check("t3 a.idx_valid", 32'(ifa.idx_valid), 0);
    check("t3 a.idx_held", 32'(ifa.idx), 0);       check("t3 a.seq_err", 32'(ifa.seq_err), 1);
    check("t3 a.err_count", 32'(ifa.err_count), 2);
    step(1, 4'b0000);
    check("t3 a.seq_err_hunt", 32'(ifa.seq_err), 0); check("t3 a.locked", 32'(ifa.locked), 0);

    // Decrement sequence with gaps on B
    step(1, 4'b1000);
    step(1, 4'b0100);
    step(0, 4'b0000);
    step(1, 4'b0010); check("t4 b.locked", 32'(ifb.locked), 1);
    step(0, 4'b1111);
    step(0, 4'b0000);
    check("t4 b.gap_idx_valid", 32'(ifb.idx_valid), 0); check("t4 b.gap_idx", 32'(ifb.idx), 1);
    check("t4 b.gap_locked", 32'(ifb.locked), 1);
    step(1, 4'b0001);
    for (int g = 0; g < 3; g++) step(0, 4'b0110);
    step(1, 4'b1000);
    check("t4 b.idx", 32'(ifb.idx), 3); check("t4 b.locked_end", 32'(ifb.locked), 1);
    check("t4 b.err_count", 32'(ifb.err_count), 0);

    // Saturation of the 2-bit counter on A
    for (int n = 0; n < 5; n++) begin
      step(1, 4'b0001); step(1, 4'b0010); step(1, 4'b0100); step(1, 4'b0000);
    end
    check("t5 a.err_sat", 32'(ifa.err_count), 3);
    step(1, 4'b0001); step(1, 4'b0010); step(1, 4'b0100);
    step(1, 4'b0000, 1);
    check("t5 a.clr_wins", 32'(ifa.err_count), 0); check("t5 a.seq_err", 32'(ifa.seq_err), 1);

    // Reset while locked with err_count=2
    for (int n = 0; n < 2; n++) begin
      step(1, 4'b0001); step(1, 4'b0010); step(1, 4'b0100); step(1, 4'b0000);
    end
    step(1, 4'b0001); step(1, 4'b0010); step(1, 4'b0100);
    check("t6 a.pre_locked", 32'(ifa.locked), 1); check("t6 a.pre_err", 32'(ifa.err_count), 2);
    step(1, 4'b1000, 1, 0);
    check("t6 a.idx_valid", 32'(ifa.idx_valid), 0); check("t6 a.idx", 32'(ifa.idx), 0);
    check("t6 a.onehot_ok", 32'(ifa.onehot_ok), 0); check("t6 a.locked", 32'(ifa.locked), 0);
    check("t6 a.seq_err", 32'(ifa.seq_err), 0);     check("t6 a.err_count", 32'(ifa.err_count), 0);
    step(1, 4'b0001);
    step(1, 4'b0010); check("t6 a.not_yet", 32'(ifa.locked), 0);
    step(1, 4'b0100); check("t6 a.relock", 32'(ifa.locked), 1);
    step(0, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
